prim_mem_responder: RTL

//  Bus responder (slave end) for the Prim CPU memory bus. Serves byte-addressed 16-bit

---
 rtl/prim_bus_pkg.sv | 23 ++
 rtl/prim_ram_word.sv | 34 +++
 rtl/prim_mem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/prim_bus_pkg.sv
// Shared Prim memory-bus definitions: responder state encoding and byte-lane select codes.
// Used by the CPU side and by every bus peripheral.
package prim_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        BEAT1 = 3'd2,
        WAIT  = 3'd3,
        ACK   = 3'd4
    } bus_state_e;

    localparam logic [1:0] BS_NONE = 2'b00;
    localparam logic [1:0] BS_LO   = 2'b01;
    localparam logic [1:0] BS_HI   = 2'b10;
    localparam logic [1:0] BS_W    = 2'b11;

    // An odd-addressed full-word access straddles two RAM words.
    function automatic logic is_split(input logic odd, input logic [1:0] bs);
        return odd && (bs == BS_W);
    endfunction

endpackage

// File: rtl/prim_ram_word.sv
// Synchronous single-port 16-bit RAM, byte write enables, one-cycle registered read.
// Each byte lane is its own array so the tools map it straight onto byte-enabled block RAM.
module prim_ram_word #(
    parameter int WAW = 15
) (
    input  logic            i_clk,
    input  logic            i_en,
    input  logic            i_we,
    input  logic [1:0]      i_be,
    input  logic [WAW-1:0]  i_addr,
    input  logic [15:0]     i_wdata,
    output logic [15:0]     o_rdata
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [7:0] mem [0:(2**WAW)-1];
        logic [7:0] rd_reg;

        always_ff @(posedge i_clk) begin
            if (i_en) begin
                if (i_we) begin
                    if (i_be[gi]) begin
                        mem[i_addr] <= i_wdata[gi*8 +: 8];
                    end
                end else begin
                    rd_reg <= mem[i_addr];
                end
            end
        end

        assign o_rdata[gi*8 +: 8] = rd_reg;
    end

endmodule

// File: rtl/prim_mem_responder.sv
// Prim memory-bus responder: byte-addressed 16-bit accesses onto a word RAM, unaligned split, WS wait states.
// Optional write protection below ROM_TOP is enabled by defining PRIM_RESP_WPROT_EN.
module prim_mem_responder
    import prim_bus_pkg::*;
#(
    parameter int          AW      = 16,
    parameter int          WS      = 0,
    parameter logic [15:0] ROM_TOP = 16'h0400
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_dat,
    output logic [15:0] o_dat,
    input  logic [1:0]  i_bs,
    input  logic        i_we,
    output logic        o_ack,
    output logic        o_wprot
);

    localparam int         WAW      = AW - 1;
    localparam logic       HAS_WAIT = (WS > 0);
    localparam logic [3:0] WS_LAST  = 4'(WS > 0 ? WS - 1 : 0);
`ifdef PRIM_RESP_WPROT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif

    bus_state_e     state_reg, state_next;
    logic [AW-1:0]  addr_reg;
    logic [1:0]     bs_reg;
    logic           we_reg;
    logic [15:0]    dat_reg;
    logic           split_reg;
    logic           first_sel_reg;
    logic [15:0]    asm_reg, asm_next;
    logic           drop_reg, drop_next;
    logic [3:0]     cnt_reg, cnt_next;
    logic           o_ack_reg, o_wprot_reg;
    logic [15:0]    o_dat_reg;

    logic           req, issue, issue_sel, ret_sel, returning, ack_next, dropped;
    logic [AW-1:0]  b_addr;
    logic [1:0]     b_bs;
    logic           b_we;
    logic [15:0]    b_dat;
    logic [WAW-1:0] b_w, ram_addr;
    logic           b_odd;
    logic [1:0]     be_raw, byte_drop, ram_be;
    logic [15:0]    ram_wdata, ram_rdata, steer;

    assign req = (state_reg == IDLE) && (i_bs != BS_NONE);

    // The first beat is issued straight from the bus in IDLE so its data is back one cycle later.
    always_comb begin
        if (state_reg == IDLE) begin
            b_addr = i_addr[AW-1:0];
            b_bs   = i_bs;
            b_we   = i_we;
            b_dat  = i_dat;
        end else begin
            b_addr = addr_reg;
            b_bs   = bs_reg;
            b_we   = we_reg;
            b_dat  = dat_reg;
        end
    end

    assign b_w       = b_addr[AW-1:1];
    assign b_odd     = b_addr[0];
    assign issue_sel = (state_reg == IDLE) ? (b_odd && !b_bs[0]) : 1'b1;
    assign issue     = req || ((state_reg == BEAT0) && split_reg);
    assign ram_addr  = (issue_sel && b_odd) ? b_w + WAW'(1) : b_w;

    // Beat plan: sel 0 touches word w, sel 1 the following (wrapping) word.
    always_comb begin
        be_raw    = b_bs;
        ram_wdata = b_dat;
        if (b_odd && !issue_sel) begin
            be_raw    = BS_HI;
            ram_wdata = {b_dat[7:0], 8'h00};
        end else if (b_odd) begin
            be_raw    = BS_LO;
            ram_wdata = {8'h00, b_dat[15:8]};
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_prot
        logic [31:0] byte_addr;
        assign byte_addr     = 32'({ram_addr, 1'(gi)});
        assign byte_drop[gi] = PROT_EN && b_we && be_raw[gi] && (byte_addr < 32'(ROM_TOP));
    end

    assign ram_be  = be_raw & ~byte_drop;
    assign dropped = issue && (byte_drop != 2'b00);

    prim_ram_word #(
        .WAW(WAW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (issue),
        .i_we    (b_we),
        .i_be    (ram_be),
        .i_addr  (ram_addr),
        .i_wdata (ram_wdata),
        .o_rdata (ram_rdata)
    );

    assign returning = (state_reg == BEAT0) || (state_reg == BEAT1);
    assign ret_sel   = (state_reg == BEAT1) ? 1'b1 : first_sel_reg;

    always_comb begin
        steer = 16'h0000;
        if (!addr_reg[0]) begin
            steer = ram_rdata & {{8{bs_reg[1]}}, {8{bs_reg[0]}}};
        end else if (!ret_sel) begin
            steer[7:0] = ram_rdata[15:8];
        end else begin
            steer[15:8] = ram_rdata[7:0];
        end
    end

    always_comb begin
        asm_next  = asm_reg;
        drop_next = drop_reg;
        if (req) begin
            asm_next  = 16'h0000;
            drop_next = dropped;
        end else begin
            if (returning && !we_reg) begin
                asm_next = asm_reg | steer;
            end
            if (dropped) begin
                drop_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next = BEAT0;
                end
            end
            BEAT0: begin
                cnt_next = 4'd0;
                if (split_reg) begin
                    state_next = BEAT1;
                end else begin
                    state_next = HAS_WAIT ? WAIT : ACK;
                end
            end
            BEAT1: begin
                cnt_next   = 4'd0;
                state_next = HAS_WAIT ? WAIT : ACK;
            end
            WAIT: begin
                if (cnt_reg == WS_LAST) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ack_next = (state_next == ACK);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            bs_reg        <= BS_NONE;
            we_reg        <= 1'b0;
            dat_reg       <= 16'h0000;
            split_reg     <= 1'b0;
            first_sel_reg <= 1'b0;
            asm_reg       <= 16'h0000;
            drop_reg      <= 1'b0;
            cnt_reg       <= 4'd0;
            o_ack_reg     <= 1'b0;
            o_wprot_reg   <= 1'b0;
            o_dat_reg     <= 16'h0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            asm_reg   <= asm_next;
            drop_reg  <= drop_next;
            if (req) begin
                addr_reg      <= b_addr;
                bs_reg        <= b_bs;
                we_reg        <= b_we;
                dat_reg       <= b_dat;
                split_reg     <= is_split(b_odd, b_bs);
                first_sel_reg <= issue_sel;
            end
            o_ack_reg   <= ack_next;
            o_wprot_reg <= ack_next && drop_next;
            if (ack_next && !we_reg) begin
                o_dat_reg <= asm_next;
            end
        end
    end

    assign o_ack   = o_ack_reg;
    assign o_wprot = o_wprot_reg;
    assign o_dat   = o_dat_reg;

endmodule
